mul_sequencer: RTL and testbench
================================

# mul_sequencer

Multi-cycle shift-add multiplier controller that feeds the register file's HI/LO path. It accepts one multiply request from decode, iterates a radix-2 shift-add over 32 cycles, applies sign correction, then issues exactly one write cycle to the register file. That write either sets {hi, lo} (MULT) or accumulates into {hi, lo} (MADD). It sits between decode/issue and the register file write port, and owns the `mul` select during its write cycle.

## Interface
Parameters:
- `WIDTH`, 32, operand width; product is 2*WIDTH.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request strobe. Sampled only in IDLE.
- `op` in 2: 1 = MULT (set HI/LO), 2 = MADD (accumulate). 0 and 3 are illegal.
- `signed_op` in 1: 1 = two's-complement operands, 0 = unsigned.
- `operand_a` in WIDTH: multiplicand.
- `operand_b` in WIDTH: multiplier.
- `busy` out 1: high from the cycle after acceptance through the WRITE cycle.
- `done` out 1: one-cycle pulse, coincident with the write.
- `rf_write_enable` out 1: register file write enable.
- `rf_mul` out 2: register file `mul` select (1 = set, 2 = accumulate, 0 outside WRITE).
- `rf_write_data_1` out WIDTH: product low word (LO).
- `rf_write_data_2` out WIDTH: product high word (HI).

## Operation
- FSM states: IDLE, CALC, SIGN, WRITE.
- **IDLE**
  - Acceptance requires `start` high and `op` equal to 1 or 2. `start` with `op` 0 or 3 is ignored and the block stays in IDLE.
  - On acceptance, latch `op`, set `neg = signed_op & (a[31] ^ b[31])`, and load magnitudes (abs when signed, raw when unsigned).
  - Load a 64-bit multiplicand register = {32'b0, |a|}, a 32-bit multiplier register = |b|, a 64-bit product = 0, and the iteration counter = 0.
  - Go to CALC.
- **CALC**
  - Each cycle: if multiplier[0] is set, product += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, count += 1.
  - After the cycle with count == 31, go to SIGN.
  - All arithmetic is modulo 2^64.
  - |0x80000000| is 0x80000000, treated as unsigned.
- **SIGN**: if `neg`, product = ~product + 1 (64-bit). Go to WRITE.
- **WRITE**
  - Drive `rf_write_enable` = 1, `rf_mul` = latched op, `rf_write_data_1` = product[31:0], `rf_write_data_2` = product[63:32], `done` = 1.
  - Next state is IDLE.
- `start` while `busy` is ignored; no queueing.
- Operands are sampled only at acceptance, so later changes to the inputs have no effect.
- `rst` in any state: next state IDLE and all outputs zero. An in-flight operation is abandoned with no write.
- All outputs are registered. They are zero whenever not in the state that asserts them.

## Timing
- Cycle 0: `start` is sampled high in IDLE.
- Cycles 1–32: CALC, with `busy` = 1.
- Cycle 33: SIGN.
- Cycle 34: WRITE, with `done`, `rf_write_enable` and `rf_mul` valid. The register file updates {hi, lo} at the end of cycle 34.
- Fixed latency: 34 cycles from the acceptance edge to the write cycle.
- Cycle 35: back in IDLE. A new `start` is accepted in cycle 35, giving back-to-back throughput of one operation per 35 cycles.
- Reset values: `busy` = 0, `done` = 0, `rf_write_enable` = 0, `rf_mul` = 0, `rf_write_data_1` = 0, `rf_write_data_2` = 0. State is IDLE.
- `rst` and `start` high in the same cycle: reset wins and nothing is accepted.

## Structure
- Shared package holds:
  - `MUL_NONE` = 2'd0, `MUL_SET` = 2'd1, `MUL_ACC` = 2'd2, so the register file and this block agree on `mul` encoding.
  - The FSM state encoding.
- Single module. The FSM and datapath are small enough that no sub-module is warranted.

## Test plan
- MULT unsigned, a=3, b=5 → in cycle 34: `rf_write_enable`=1, `rf_mul`=1, LO=0x0000000F, HI=0x00000000, `done`=1 for exactly one cycle.
- MULT unsigned, a=b=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- MULT signed, a=0xFFFFFFFF (−1), b=2 → HI=0xFFFFFFFF, LO=0xFFFFFFFE. Signed a=0x80000000, b=0x80000000 → HI=0x40000000, LO=0.
- MADD signed, a=7, b=6, after a prior MULT 3×5 into the register file → `rf_mul`=2, LO=42, HI=0. Register file then reads {hi, lo} = 57.
- `start` pulsed at cycles 5 and 20 during an operation, plus `start` with `op`=3 in IDLE → all ignored: one write only, and `busy` stays low for the `op`=3 request.
- `rst` asserted at cycle 10 of CALC → next cycle is IDLE with all outputs 0, no `rf_write_enable` ever asserted, and a new `start` is accepted the cycle after `rst` deasserts.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg: shared mul-select encoding and FSM states for the shift-add multiplier
package mul_sequencer_pkg;
  localparam logic [1:0] MUL_NONE = 2'd0;
  localparam logic [1:0] MUL_SET  = 2'd1;
  localparam logic [1:0] MUL_ACC  = 2'd2;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_SIGN  = 2'd2,
    S_WRITE = 2'd3
  } state_t;
endpackage

// File: rtl/mul_sequencer.sv
// mul_sequencer: radix-2 shift-add multiplier issuing one HI/LO set or accumulate write
module mul_sequencer
  import mul_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic             rf_write_enable,
  output logic [1:0]       rf_mul,
  output logic [WIDTH-1:0] rf_write_data_1,
  output logic [WIDTH-1:0] rf_write_data_2
);
  localparam int CW = $clog2(WIDTH);
  state_t             state;
  logic [1:0]         op_q;
  logic               neg;
  logic [2*WIDTH-1:0] mcand, prod, prod_next, prod_fix;
  logic [WIDTH-1:0]   mplier, mag_a, mag_b;
  logic [CW-1:0]      count;
  logic               accept;
  // operand magnitudes, one shift-add step and the final sign fix-up
  always_comb begin
    mag_a     = (signed_op && operand_a[WIDTH-1]) ? -operand_a : operand_a;
    mag_b     = (signed_op && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    accept    = start && (op == MUL_SET || op == MUL_ACC);
    prod_next = mplier[0] ? prod + mcand : prod;
    prod_fix  = neg ? -prod : prod;
  end
  // control FSM with datapath registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      op_q            <= MUL_NONE;
      neg             <= 1'b0;
      mcand           <= '0;
      mplier          <= '0;
      prod            <= '0;
      count           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      rf_write_enable <= 1'b0;
      rf_mul          <= MUL_NONE;
      rf_write_data_1 <= '0;
      rf_write_data_2 <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          op_q   <= op;
          neg    <= signed_op & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
          mcand  <= {{WIDTH{1'b0}}, mag_a};
          mplier <= mag_b;
          prod   <= '0;
          count  <= '0;
          busy   <= 1'b1;
          state  <= S_CALC;
        end
        S_CALC: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          state  <= (count == CW'(WIDTH - 1)) ? S_SIGN : S_CALC;
        end
        S_SIGN: begin
          done            <= 1'b1;
          rf_write_enable <= 1'b1;
          rf_mul          <= op_q;
          rf_write_data_1 <= prod_fix[WIDTH-1:0];
          rf_write_data_2 <= prod_fix[2*WIDTH-1:WIDTH];
          state           <= S_WRITE;
        end
        default: begin
          busy            <= 1'b0;
          done            <= 1'b0;
          rf_write_enable <= 1'b0;
          rf_mul          <= MUL_NONE;
          rf_write_data_1 <= '0;
          rf_write_data_2 <= '0;
          state           <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed and randomized checks of mul_sequencer against an arithmetic model
module tb_mul_sequencer;
  import mul_sequencer_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        signed_op = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy, done, rf_write_enable;
  logic [1:0]  rf_mul;
  logic [31:0] rf_write_data_1, rf_write_data_2;
  int          checks = 0;
  int          failures = 0;
  int          writes = 0;
  logic [63:0] hilo = '0;
  int          w0;

  mul_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .signed_op(signed_op),
    .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
    .rf_write_enable(rf_write_enable), .rf_mul(rf_mul),
    .rf_write_data_1(rf_write_data_1), .rf_write_data_2(rf_write_data_2)
  );

  always #5 clk = ~clk;

  // register file consumer: counts writes and applies set/accumulate to HI/LO
  always @(negedge clk)
    if (rf_write_enable) begin
      writes++;
      hilo = (rf_mul == MUL_SET) ? {rf_write_data_2, rf_write_data_1}
                                 : hilo + {rf_write_data_2, rf_write_data_1};
    end

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    pa = s ? longint'($signed(a)) : longint'({32'b0, a});
    pb = s ? longint'($signed(b)) : longint'({32'b0, b});
    return 64'(pa * pb);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic outputs_zero(input string tag);
    chk(tag, {busy, done, rf_write_enable, rf_mul, rf_write_data_2, rf_write_data_1},
        {1'b0, 1'b0, 1'b0, 2'd0, 64'd0});
  endtask

  // issue one request at this negedge and follow it through the write cycle
  task automatic run_op(input logic [1:0] o, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input bit pulse);
    logic [63:0] exp;
    logic        early, bz;
    exp = model(s, a, b);
    start = 1'b1; op = o; signed_op = s; operand_a = a; operand_b = b;
    @(negedge clk);
    early = 1'b0; bz = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      early |= done | rf_write_enable | (rf_mul != MUL_NONE);
      bz &= busy;
      start = pulse && (c == 5 || c == 20);
      op = MUL_SET; signed_op = $urandom_range(0, 1);
      operand_a = $urandom; operand_b = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    chk("early_write", {31'd0, early}, 32'd0);
    chk("busy_calc", {31'd0, bz}, 32'd1);
    chk("write_ctl", {busy, done, rf_write_enable, rf_mul}, {1'b1, 1'b1, 1'b1, o});
    chk("product", {rf_write_data_2, rf_write_data_1}, exp);
    @(negedge clk);
    outputs_zero("after_write");
  endtask

  initial begin
    @(negedge clk);
    outputs_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);
    outputs_zero("idle_after_reset");
    run_op(MUL_SET, 1'b0, 32'd3, 32'd5, 1'b0);
    run_op(MUL_SET, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(MUL_SET, 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op(MUL_SET, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(MUL_SET, 1'b0, 32'd3, 32'd5, 1'b0);
    run_op(MUL_ACC, 1'b1, 32'd7, 32'd6, 1'b0);
    chk("hilo_madd", hilo, 64'd57);
    w0 = writes;
    run_op(MUL_SET, 1'b0, $urandom, $urandom, 1'b1);
    chk("one_write_pulsed", 64'(writes - w0), 64'd1);
    start = 1'b1; op = 2'd3; signed_op = 1'b0; operand_a = 32'd9; operand_b = 32'd9;
    @(negedge clk);
    start = 1'b1; op = 2'd0;
    chk("busy_op3", {63'd0, busy}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    chk("busy_op0", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    chk("no_write_illegal", 64'(writes - w0), 64'd1);
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a, b;
      a = (i == 0) ? 32'h8000_0000 : (i == 1) ? 32'h0 : $urandom;
      b = (i == 0) ? 32'h7FFF_FFFF : $urandom;
      run_op($urandom_range(0, 1) ? MUL_ACC : MUL_SET, 1'($urandom_range(0, 1)), a, b, 1'b0);
    end
    w0 = writes;
    start = 1'b1; op = MUL_SET; signed_op = 1'b0; operand_a = $urandom; operand_b = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    outputs_zero("reset_mid_calc");
    rst = 1'b0;
    run_op(MUL_ACC, 1'b1, 32'hFFFF_FFF9, 32'd6, 1'b0);
    repeat (40) @(negedge clk);
    chk("abandoned_no_write", 64'(writes - w0), 64'd1);
    rst = 1'b1; start = 1'b1; op = MUL_SET;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_beats_start", {63'd0, busy}, 64'd0);
    @(negedge clk);
    outputs_zero("rst_start_idle");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
